// File: rtl/nand_share_arb_pkg.sv
// Shared definitions for the NAND-sharing arbiter: FSM encoding and sizing helper.
package nand_share_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index width needed to address n items (never less than one bit).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ic_7400.sv
// One gate of a 7400 quad 2-input NAND; the only NAND in the arbiter.
module ic_7400 (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a & b);

endmodule

// File: rtl/nand_share_arb.sv
// Round-robin arbiter letting NREQ requesters time-share a single NAND gate.
module nand_share_arb
    import nand_share_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CNTW = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          a,
    input  logic [NREQ-1:0]          b,
    output logic [NREQ-1:0]          ack,
    output logic                     y,
    output logic [clog2(NREQ)-1:0]   gnt_id,
    output logic                     busy,
    output logic [CNTW-1:0]          op_cnt
);

    localparam int unsigned IDW = clog2(NREQ);

    state_t              state_q;
    state_t              state_d;
    logic [IDW-1:0]      ptr_q;
    logic [IDW-1:0]      ptr_d;
    logic                op_a_q;
    logic                op_a_d;
    logic                op_b_q;
    logic                op_b_d;
    logic [IDW-1:0]      gnt_d;
    logic [NREQ-1:0]     ack_d;
    logic                y_d;
    logic                busy_d;
    logic [CNTW-1:0]     cnt_d;
    logic                nand_y;
    logic                pick_found;
    logic [IDW-1:0]      pick_idx;

    // First set request at or after p, ascending with wrap; returns {found, index}.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  p);
        logic [31:0]    sum;
        logic [IDW-1:0] ix;
        logic           found;
        logic [IDW-1:0] win;
        found = 1'b0;
        win   = '0;
        // Walk from the far end back toward p so the nearest hit is written last.
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            sum = (32'(p) + 32'(k)) % NREQ;
            ix  = IDW'(sum);
            if (r[ix]) begin
                found = 1'b1;
                win   = ix;
            end
        end
        return {found, win};
    endfunction

    // Shared gate evaluates only the latched operands.
    ic_7400 u_gate (
        .a (op_a_q),
        .b (op_b_q),
        .y (nand_y)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        gnt_d   = gnt_id;
        ack_d   = '0;
        y_d     = y;
        cnt_d   = op_cnt;
        {pick_found, pick_idx} = rr_pick(req, ptr_q);

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    op_a_d  = a[pick_idx];
                    op_b_d  = b[pick_idx];
                    gnt_d   = pick_idx;
                    ptr_d   = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                y_d     = nand_y;
                ack_d   = NREQ'(1) << gnt_id;
                cnt_d   = op_cnt + 1'b1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset also aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            op_a_q  <= 1'b0;
            op_b_q  <= 1'b0;
            gnt_id  <= '0;
            ack     <= '0;
            y       <= 1'b1;
            busy    <= 1'b0;
            op_cnt  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            gnt_id  <= gnt_d;
            ack     <= ack_d;
            y       <= y_d;
            busy    <= busy_d;
            op_cnt  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_nand_share_arb.sv
// Self-checking bench: timeline reference model plus directed literal cases and random traffic.
module tb_nand_share_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned CNTW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] a;
    logic [NREQ-1:0] b;
    logic [NREQ-1:0] ack;
    logic            y;
    logic [1:0]      gnt_id;
    logic            busy;
    logic [CNTW-1:0] op_cnt;

    int checks = 0;
    int errors = 0;

    nand_share_arb #(
        .NREQ (NREQ),
        .CNTW (CNTW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .a      (a),
        .b      (b),
        .ack    (ack),
        .y      (y),
        .gnt_id (gnt_id),
        .busy   (busy),
        .op_cnt (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an operation latched at edge L shows ack after edge L+1,
    // and the gate is free to latch again at edge L+3.
    initial begin : model_cmp
        int              e;
        int              lat;
        int              w;
        int              idx;
        int              ptr_m;
        int              gid_m;
        bit              pend;
        bit              mvalid;
        bit              rst_seen;
        logic [CNTW-1:0] cnt_m;
        logic            py;
        logic [NREQ-1:0] ack_m;
        logic            busy_m;
        e = 0; lat = -100; pend = 0; mvalid = 0;
        ptr_m = 0; gid_m = 0; cnt_m = '0; py = 1'b1;
        forever begin
            @(posedge clk);
            e++;
            rst_seen = !rst_n;
            if (!rst_n) begin
                mvalid = 1;
                pend   = 0;
                ptr_m  = 0;
                gid_m  = 0;
                cnt_m  = '0;
            end else begin
                if (pend && e == lat + 1) cnt_m = cnt_m + 1'b1;
                if ((!pend || e >= lat + 3) && req != '0) begin
                    w = -1;
                    for (int k = 0; k < int'(NREQ); k++) begin
                        idx = (ptr_m + k) % int'(NREQ);
                        if (w < 0 && ((req >> idx) & 1) != 0) w = idx;
                    end
                    gid_m = w;
                    ptr_m = (w + 1) % int'(NREQ);
                    py    = ((((a & b) >> w) & 1) == 0);
                    lat   = e;
                    pend  = 1;
                end
            end
            busy_m = pend && (e == lat || e == lat + 1);
            ack_m  = (pend && e == lat + 1) ? (NREQ'(1) << gid_m) : '0;
            #1;
            if (mvalid) begin
                chk("m_ack", 32'(ack), 32'(ack_m));
                chk("m_busy", 32'(busy), 32'(busy_m));
                chk("m_gnt", 32'(gnt_id), gid_m);
                chk("m_cnt", 32'(op_cnt), 32'(cnt_m));
                if (ack_m != '0) chk("m_y", 32'(y), 32'(py));
                if (rst_seen) chk("m_y_rst", 32'(y), 1);
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Polls falling edges until an ack shows up, bounded.
    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ack == '0 && cyc < 12);
        chk("ack_seen", 32'(ack != '0), 1);
    endtask

    function automatic logic [NREQ-1:0] put_bit(input logic [NREQ-1:0] v,
                                                input logic [NREQ-1:0] m, input logic val);
        return val ? (v | m) : (v & ~m);
    endfunction

    // Single-requester operation from IDLE with literal expectations.
    task automatic do_op(input int id, input logic av, input logic bv,
                         input logic exp_y, input int exp_cnt, input string name);
        logic [NREQ-1:0] m;
        int c;
        m   = NREQ'(1) << id;
        a   = put_bit(a, m, av);
        b   = put_bit(b, m, bv);
        req = m;
        wait_ack(c);
        chk({name, "_lat"}, c, 2);
        chk({name, "_ack"}, 32'(ack), 32'(m));
        chk({name, "_y"}, 32'(y), 32'(exp_y));
        chk({name, "_gnt"}, 32'(gnt_id), id);
        chk({name, "_cnt"}, 32'(op_cnt), exp_cnt);
        req = '0;
        @(negedge clk);
    endtask

    initial begin : stim
        int c;
        logic [NREQ-1:0] m;
        logic av;
        logic bv;
        logic [3:0] fy;

        rst_n = 1'b0;
        req = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_y", 32'(y), 1);
        chk("rst_gnt", 32'(gnt_id), 0);
        chk("rst_cnt", 32'(op_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // Single operation right after reset.
        do_op(0, 1'b1, 1'b1, 1'b0, 1, "single");

        // Truth table through requester 2.
        apply_reset();
        do_op(2, 1'b0, 1'b0, 1'b1, 1, "tt00");
        do_op(2, 1'b0, 1'b1, 1'b1, 2, "tt01");
        do_op(2, 1'b1, 1'b0, 1'b1, 3, "tt10");
        do_op(2, 1'b1, 1'b1, 1'b0, 4, "tt11");

        // Fairness with every requester held high.
        apply_reset();
        a  = 4'b1010;
        b  = 4'b0110;
        fy = 4'b1101;
        req = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            wait_ack(c);
            chk("fair_gap", c, (n == 0) ? 2 : 3);
            chk("fair_ack", 32'(ack), 32'(NREQ'(1) << (n % 4)));
            chk("fair_y", 32'(y), 32'((fy >> (n % 4)) & 4'd1));
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Operand change after latch must not reach y.
        apply_reset();
        a = 4'b0010; b = 4'b0010; req = 4'b0010;
        @(negedge clk);
        a = 4'b0000; b = 4'b0000;
        wait_ack(c);
        chk("stab_ack", 32'(ack), 32'(4'b0010));
        chk("stab_y", 32'(y), 0);
        req = '0;
        @(negedge clk);

        // Reset during EVAL aborts the operation.
        apply_reset();
        a = 4'b0001; b = 4'b0001; req = 4'b0001;
        @(negedge clk);
        chk("abort_busy_eval", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ack", 32'(ack), 0);
        chk("abort_cnt", 32'(op_cnt), 0);
        chk("abort_busy", 32'(busy), 0);
        rst_n = 1'b1;
        req = 4'b1001;
        wait_ack(c);
        chk("abort_ptr0_ack", 32'(ack), 32'(4'b0001));
        chk("abort_ptr0_gnt", 32'(gnt_id), 0);
        req = '0;
        @(negedge clk);
        do_op(3, 1'b1, 1'b0, 1'b1, 2, "after_abort");

        // Counter wrap with a 4-bit counter.
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            av = 1'($urandom_range(0, 1));
            bv = 1'($urandom_range(0, 1));
            do_op(i % 4, av, bv, ~(av & bv), (i + 1) % 16, "wrap");
        end

        // Random traffic honouring the hold-until-ack contract, with sporadic resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < int'(NREQ); i++) begin
                m = NREQ'(1) << i;
                if ((ack & m) != '0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        a = put_bit(a, m, 1'($urandom_range(0, 1)));
                        b = put_bit(b, m, 1'($urandom_range(0, 1)));
                    end else begin
                        req = req & ~m;
                    end
                end else if ((req & m) == '0 && $urandom_range(0, 2) == 0) begin
                    a   = put_bit(a, m, 1'($urandom_range(0, 1)));
                    b   = put_bit(b, m, 1'($urandom_range(0, 1)));
                    req = req | m;
                end
            end
        end
        rst_n = 1'b1;
        req   = '0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
